// File: rtl/bus_io_bridge_if.sv
// Processor-side bus of bus_io_bridge: address, write data and strobe out, read data back.
interface bus_io_bridge_if;
    logic [15:0] ADDR;
    logic [15:0] DOUT;
    logic        W;
    logic [15:0] DIN;

    modport master (output ADDR, output DOUT, output W, input DIN);
    modport slave  (input ADDR, input DOUT, input W, output DIN);
endinterface

// File: rtl/bus_io_bridge.sv
// Memory-mapped bridge: RAM, LEDR, synchronized SW and a 16-bit interval timer, all read with 1-cycle latency.
// Optional macro BRIDGE_HEX_EN adds six 7-segment registers at 0x2000..0x2005.
module bus_io_bridge #(
    parameter int unsigned LED_W    = 10,
    parameter int unsigned SW_W     = 10,
    parameter logic [3:0]  RAM_PAGE = 4'h0
) (
    input  logic              Clock,
    input  logic              Resetn,
    bus_io_bridge_if.slave    bus,
    output logic              ram_wren,
    input  logic [15:0]       ram_q,
    input  logic [SW_W-1:0]   SW,
    output logic [LED_W-1:0]  LEDR,
    output logic              timer_irq
`ifdef BRIDGE_HEX_EN
    ,
    output logic [6:0]        HEX0,
    output logic [6:0]        HEX1,
    output logic [6:0]        HEX2,
    output logic [6:0]        HEX3,
    output logic [6:0]        HEX4,
    output logic [6:0]        HEX5
`endif
);
    localparam int unsigned DW = 16;

    logic [3:0]       page;
    logic             ram_sel;
    logic             wr_led, wr_tload, wr_tstat, wr_tctrl, expire;
    logic [DW-1:0]    io_d, io_q;
    logic             sel_q;
    logic [LED_W-1:0] led_d, led_q;
    logic [SW_W-1:0]  sw_meta_q, sw_sync_q;
    logic [DW-1:0]    tload_d, tload_q, cnt_d, cnt_q;
    logic             run_d, run_q, per_d, per_q, tf_d, tf_q;
`ifdef BRIDGE_HEX_EN
    logic             wr_hex;
    logic [6:0]       hex_d [6];
    logic [6:0]       hex_q [6];
`endif

    // Address decode; RAM page wins over any I/O page it might alias.
    always_comb begin
        page     = bus.ADDR[15:12];
        ram_sel  = (page == RAM_PAGE);
        ram_wren = bus.W && ram_sel;
        wr_led   = bus.W && !ram_sel && (page == 4'h1);
        wr_tload = bus.W && !ram_sel && (bus.ADDR == 16'h5000);
        wr_tstat = bus.W && !ram_sel && (bus.ADDR == 16'h5001);
        wr_tctrl = bus.W && !ram_sel && (bus.ADDR == 16'h5002);
        expire   = run_q && (cnt_q == 16'h0000);
`ifdef BRIDGE_HEX_EN
        wr_hex   = bus.W && !ram_sel && (page == 4'h2) &&
                   (bus.ADDR[11:3] == 9'h000) && (bus.ADDR[2:0] < 3'd6);
`endif
    end

    // I/O read mux built from current register values, so a same-cycle write reads old data.
    always_comb begin
        io_d = '0;
        if (!ram_sel) begin
            if (page == 4'h1) begin
                io_d = DW'(led_q);
            end else if (page == 4'h3) begin
                io_d = DW'(sw_sync_q);
            end else if (page == 4'h5) begin
                case (bus.ADDR[11:0])
                    12'h000: io_d = tload_q;
                    12'h001: io_d = {15'b0, tf_q};
                    12'h002: io_d = {14'b0, per_q, run_q};
                    12'h003: io_d = cnt_q;
                    default: io_d = '0;
                endcase
`ifdef BRIDGE_HEX_EN
            end else if ((page == 4'h2) && (bus.ADDR[11:3] == 9'h000) && (bus.ADDR[2:0] < 3'd6)) begin
                io_d = DW'(hex_q[bus.ADDR[2:0]]);
`endif
            end
        end
    end

    // Register and timer next-state; a TLOAD write pre-empts expiry and count for that cycle.
    always_comb begin
        led_d   = led_q;
        tload_d = tload_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        per_d   = per_q;
        tf_d    = tf_q;
        if (wr_led) led_d = bus.DOUT[LED_W-1:0];
        if (wr_tload) begin
            tload_d = bus.DOUT;
            cnt_d   = bus.DOUT;
        end else if (expire) begin
            tf_d = 1'b1;
            if (per_q) cnt_d = tload_q;
            else       run_d = 1'b0;
        end else if (run_q) begin
            cnt_d = cnt_q - 16'd1;
        end
        if (wr_tstat && !expire) tf_d = 1'b0;
        if (wr_tctrl) begin
            run_d = bus.DOUT[0];
            per_d = bus.DOUT[1];
        end
`ifdef BRIDGE_HEX_EN
        hex_d = hex_q;
        if (wr_hex) hex_d[bus.ADDR[2:0]] = bus.DOUT[6:0];
`endif
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_q     <= 1'b0;
            io_q      <= '0;
            led_q     <= '0;
            sw_meta_q <= '0;
            sw_sync_q <= '0;
            tload_q   <= '0;
            cnt_q     <= '0;
            run_q     <= 1'b0;
            per_q     <= 1'b0;
            tf_q      <= 1'b0;
`ifdef BRIDGE_HEX_EN
            for (int i = 0; i < 6; i++) hex_q[i] <= 7'h7F;
`endif
        end else begin
            sel_q     <= ram_sel;
            io_q      <= io_d;
            led_q     <= led_d;
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
            tload_q   <= tload_d;
            cnt_q     <= cnt_d;
            run_q     <= run_d;
            per_q     <= per_d;
            tf_q      <= tf_d;
`ifdef BRIDGE_HEX_EN
            hex_q     <= hex_d;
`endif
        end
    end

    assign bus.DIN   = sel_q ? ram_q : io_q;
    assign LEDR      = led_q;
    assign timer_irq = tf_q;
`ifdef BRIDGE_HEX_EN
    assign HEX0 = hex_q[0];
    assign HEX1 = hex_q[1];
    assign HEX2 = hex_q[2];
    assign HEX3 = hex_q[3];
    assign HEX4 = hex_q[4];
    assign HEX5 = hex_q[5];
`endif
endmodule

// File: tb/tb_bus_io_bridge.sv
// Bench for bus_io_bridge: directed literal checks plus random traffic against a behavioural model.
module tb_bus_io_bridge;
    localparam int unsigned LED_W    = 10;
    localparam int unsigned SW_W     = 10;
    localparam logic [3:0]  RAM_PAGE = 4'h0;

    logic              Clock = 1'b0;
    logic              Resetn;
    bit                clk_run = 1'b1;
    logic              ram_wren;
    logic [15:0]       ram_q;
    logic [SW_W-1:0]   SW;
    logic [LED_W-1:0]  LEDR;
    logic              timer_irq;
    bus_io_bridge_if   bus();
`ifdef BRIDGE_HEX_EN
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [6:0] dut_hex [6];
    assign dut_hex[0] = HEX0;
    assign dut_hex[1] = HEX1;
    assign dut_hex[2] = HEX2;
    assign dut_hex[3] = HEX3;
    assign dut_hex[4] = HEX4;
    assign dut_hex[5] = HEX5;
`endif

    bus_io_bridge #(.LED_W(LED_W), .SW_W(SW_W), .RAM_PAGE(RAM_PAGE)) dut (
        .Clock(Clock), .Resetn(Resetn), .bus(bus.slave), .ram_wren(ram_wren), .ram_q(ram_q),
        .SW(SW), .LEDR(LEDR), .timer_irq(timer_irq)
`ifdef BRIDGE_HEX_EN
        , .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
`endif
    );

    initial forever begin
        #5;
        if (clk_run) Clock = ~Clock;
    end

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model of the architectural state visible to the processor.
    logic [LED_W-1:0] m_led;
    logic [SW_W-1:0]  m_sw1, m_sw2;
    logic [15:0]      m_tload, m_cnt, m_prev_io;
    bit               m_run, m_per, m_tf, m_prev_ram;
    logic [6:0]       m_hex [6];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_led = '0; m_sw1 = '0; m_sw2 = '0;
        m_tload = '0; m_cnt = '0; m_run = 0; m_per = 0; m_tf = 0;
        m_prev_ram = 0; m_prev_io = '0;
        for (int i = 0; i < 6; i++) m_hex[i] = 7'h7F;
    endtask

    task automatic model_edge();
        logic [15:0] a, d, rv;
        bit w, is_ram, fire;
        a = bus.ADDR; d = bus.DOUT; w = bus.W;
        is_ram = (a[15:12] == RAM_PAGE);
        rv = '0;
        if (!is_ram) begin
            if (a[15:12] == 4'h1)      rv = 16'(m_led);
            else if (a[15:12] == 4'h3) rv = 16'(m_sw2);
            else if (a == 16'h5000)    rv = m_tload;
            else if (a == 16'h5001)    rv = 16'(m_tf);
            else if (a == 16'h5002)    rv = 16'({m_per, m_run});
            else if (a == 16'h5003)    rv = m_cnt;
`ifdef BRIDGE_HEX_EN
            else if (a >= 16'h2000 && a <= 16'h2005) rv = 16'(m_hex[a - 16'h2000]);
`endif
        end
        m_prev_ram = is_ram;
        m_prev_io  = rv;
        m_sw2 = m_sw1;
        m_sw1 = SW;
        if (w && !is_ram) begin
            if (a[15:12] == 4'h1) m_led = d[LED_W-1:0];
`ifdef BRIDGE_HEX_EN
            if (a >= 16'h2000 && a <= 16'h2005) m_hex[a - 16'h2000] = d[6:0];
`endif
        end
        fire = m_run && (m_cnt == 0);
        if (w && !is_ram && a == 16'h5000) begin
            m_tload = d;
            m_cnt   = d;
        end else if (fire) begin
            m_tf = 1;
            if (m_per) m_cnt = m_tload;
            else       m_run = 0;
        end else if (m_run) begin
            m_cnt = m_cnt - 1;
        end
        if (w && !is_ram && a == 16'h5001 && !fire) m_tf = 0;
        if (w && !is_ram && a == 16'h5002) begin
            m_run = d[0];
            m_per = d[1];
        end
    endtask

    // Per-cycle comparison of every meaningful output against the model.
    always @(negedge Clock) begin
        if (chk_en && Resetn) begin
            check("DIN", bus.DIN, m_prev_ram ? ram_q : m_prev_io);
            check("LEDR", 16'(LEDR), 16'(m_led));
            check("timer_irq", 16'(timer_irq), 16'(m_tf));
            check("ram_wren", 16'(ram_wren), 16'(bus.W && (bus.ADDR[15:12] == RAM_PAGE)));
`ifdef BRIDGE_HEX_EN
            for (int i = 0; i < 6; i++) check("HEX", 16'(dut_hex[i]), 16'(m_hex[i]));
`endif
        end
    end

    task automatic step();
        @(posedge Clock);
        if (!Resetn) model_reset();
        else         model_edge();
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [15:0] d, input bit w);
        bus.ADDR = a; bus.DOUT = d; bus.W = w;
        ram_q = 16'($urandom);
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        drive(a, d, 1'b1);
        step();
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string name);
        drive(a, 16'h0000, 1'b0);
        step();
        check(name, bus.DIN, exp);
    endtask

    task automatic idle();
        drive(16'h7000, 16'h0000, 1'b0);
        step();
    endtask

    initial begin
        logic [15:0] a, d;
        Resetn = 1'b0;
        SW = '0;
        drive(16'h7000, 16'h0000, 1'b0);
        model_reset();
        repeat (3) step();
        Resetn = 1'b1;
        check("reset DIN", bus.DIN, 16'h0000);
        check("reset LEDR", 16'(LEDR), 16'h0000);
        check("reset irq", 16'(timer_irq), 16'h0000);
`ifdef BRIDGE_HEX_EN
        check("reset HEX0", 16'(HEX0), 16'h007F);
        check("reset HEX5", 16'(HEX5), 16'h007F);
`endif
        chk_en = 1'b1;

        // RAM path
        drive(16'h0005, 16'h1234, 1'b1);
        #1 check("ram_wren write", 16'(ram_wren), 16'h0001);
        step();
        drive(16'h0005, 16'h0000, 1'b0);
        step();
        ram_q = 16'h1234;
        #1 check("RAM read DIN", bus.DIN, 16'h1234);
        drive(16'h1000, 16'h0000, 1'b1);
        #1 check("ram_wren io", 16'(ram_wren), 16'h0000);
        step();

        // LED and switches
        wr(16'h1000, 16'h03FF);
        check("LEDR write", 16'(LEDR), 16'h03FF);
        SW = 10'h155;
        idle();
        idle();
        rd(16'h3000, 16'h0155, "SW read");
        rd(16'h7000, 16'h0000, "unmapped read");
        rd(16'h1000, 16'h03FF, "LEDR read");

        // One-shot timer
        wr(16'h5000, 16'h0003);
        wr(16'h5002, 16'h0001);
        rd(16'h5003, 16'h0003, "CNT 3");
        rd(16'h5003, 16'h0002, "CNT 2");
        rd(16'h5003, 16'h0001, "CNT 1");
        rd(16'h5003, 16'h0000, "CNT 0");
        check("one-shot TF", 16'(timer_irq), 16'h0001);
        rd(16'h5002, 16'h0000, "RUN cleared");
        rd(16'h5003, 16'h0000, "CNT holds");
        rd(16'h5001, 16'h0001, "TSTAT read");
        wr(16'h5001, 16'h0000);
        check("TF clear", 16'(timer_irq), 16'h0000);

        // Periodic timer and TSTAT/expiry collision
        wr(16'h5000, 16'h0002);
        wr(16'h5002, 16'h0003);
        idle();
        idle();
        check("periodic early", 16'(timer_irq), 16'h0000);
        idle();
        check("periodic first", 16'(timer_irq), 16'h0001);
        rd(16'h5003, 16'h0002, "CNT reload");
        wr(16'h5001, 16'h0000);
        check("periodic cleared", 16'(timer_irq), 16'h0000);
        wr(16'h5001, 16'h0000);
        check("TSTAT vs expiry", 16'(timer_irq), 16'h0001);
        wr(16'h5002, 16'h0000);

`ifdef BRIDGE_HEX_EN
        wr(16'h2003, 16'h0040);
        check("HEX3 write", 16'(HEX3), 16'h0040);
        rd(16'h2003, 16'h0040, "HEX3 read");
        rd(16'h2006, 16'h0000, "HEX unmapped");
`endif

        // Asynchronous reset with the clock stopped
        wr(16'h1000, 16'h03FF);
        wr(16'h5000, 16'h0000);
        wr(16'h5002, 16'h0003);
        rd(16'h1000, 16'h03FF, "pre-reset DIN");
        check("pre-reset irq", 16'(timer_irq), 16'h0001);
        @(negedge Clock);
        clk_run = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        check("async DIN", bus.DIN, 16'h0000);
        check("async LEDR", 16'(LEDR), 16'h0000);
        check("async irq", 16'(timer_irq), 16'h0000);
        model_reset();
        #2 Resetn = 1'b1;
        drive(16'h7000, 16'h0000, 1'b0);
        clk_run = 1'b1;
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 7))
                0:       a = {RAM_PAGE, 12'($urandom)};
                1:       a = {4'h1, 12'($urandom)};
                2:       a = {4'h3, 12'($urandom)};
                3, 4:    a = 16'h5000 + 16'($urandom_range(0, 3));
                5:       a = {4'h5, 12'($urandom)};
                6:       a = 16'h2000 + 16'($urandom_range(0, 7));
                default: a = 16'($urandom);
            endcase
            d = (a == 16'h5000) ? 16'($urandom_range(0, 5)) : 16'($urandom);
            if ($urandom_range(0, 15) == 0) SW = SW_W'($urandom);
            drive(a, d, 1'($urandom_range(0, 1)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
